// File: rtl/neptuno_i2s_rx_pkg.sv
// Shared constants for the I2S receiver.
// Bit-count width and saturation value.
package neptuno_i2s_rx_pkg;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

endpackage

// File: rtl/neptuno_sync.sv
// Single-bit multi-flop synchroniser, async active-low reset.
// Ports: clk, reset_n, d (async in), q (synced out).
module neptuno_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/neptuno_i2s_rx.sv
// Philips I2S slave receiver: deserialises sclk/lrclk/sdata into stereo pairs.
// Ports: clk, reset_n, sclk, lrclk, sdata -> left_chan, right_chan, valid, locked.
module neptuno_i2s_rx
  import neptuno_i2s_rx_pkg::*;
#(
  parameter int AUDIO_DW    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                valid,
  output logic                locked
);

  logic sclk_s;
  logic lr_s;
  logic sd_s;

  neptuno_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (sclk),
    .q      (sclk_s)
  );

  neptuno_sync #(.STAGES(SYNC_STAGES)) u_sync_lr (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (lrclk),
    .q      (lr_s)
  );

  neptuno_sync #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (sdata),
    .q      (sd_s)
  );

  // Edge detect is registered together with the sampled data and
  // word select so the framing logic sees one aligned strobe.
  logic sclk_prev_q;
  logic rise_q;
  logic d_q;
  logic lr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      d_q         <= 1'b0;
      lr_q        <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      rise_q      <= sclk_s & ~sclk_prev_q;
      d_q         <= sd_s;
      lr_q        <= lr_s;
    end
  end

  logic [CNT_W-1:0]    cnt_q;
  logic [AUDIO_DW-1:0] shift_q;
  logic [AUDIO_DW-1:0] hold_q;
  logic [AUDIO_DW-1:0] left_q;
  logic [AUDIO_DW-1:0] right_q;
  logic                framed_q;
  logic                have_left_q;
  logic                lr_prev_q;
  logic                valid_q;
  logic                locked_q;

  // Current word with this edge's bit merged in; bits beyond the
  // sample width fall off, short words keep zero LSBs.
  logic [AUDIO_DW-1:0] word_d;
  logic                bound_d;

  always_comb begin
    word_d = shift_q;
    for (int i = 0; i < AUDIO_DW; i++) begin
      if (int'(cnt_q) == AUDIO_DW - 1 - i) begin
        word_d[i] = d_q;
      end
    end
  end

  assign bound_d = (lr_q != lr_prev_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      framed_q    <= 1'b0;
      have_left_q <= 1'b0;
      lr_prev_q   <= 1'b1;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rise_q) begin
        if (bound_d) begin
          if (framed_q) begin
            if (!lr_prev_q) begin
              hold_q      <= word_d;
              have_left_q <= 1'b1;
            end else if (have_left_q) begin
              left_q      <= hold_q;
              right_q     <= word_d;
              valid_q     <= 1'b1;
              locked_q    <= 1'b1;
              have_left_q <= 1'b0;
            end
          end
          framed_q  <= 1'b1;
          cnt_q     <= '0;
          shift_q   <= '0;
          lr_prev_q <= lr_q;
        end else begin
          shift_q <= word_d;
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign valid      = valid_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_neptuno_i2s_rx.sv
// Self-checking bench for neptuno_i2s_rx.
// Drives Philips I2S frames and compares captured pairs to a word-level model.
`timescale 1ns/1ps
module tb_neptuno_i2s_rx;

  localparam int DW = 16;

  logic          clk;
  logic          reset_n;
  logic          sclk;
  logic          lrclk;
  logic          sdata;
  logic [DW-1:0] left_chan;
  logic [DW-1:0] right_chan;
  logic          valid;
  logic          locked;

  neptuno_i2s_rx #(.AUDIO_DW(DW), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sclk      (sclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .left_chan (left_chan),
    .right_chan(right_chan),
    .valid     (valid),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_r[$];
  logic [DW-1:0] cap_l[$];
  logic [DW-1:0] cap_r[$];
  int            wide = 0;
  logic          valid_d = 1'b0;
  logic          pend = 1'b0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      cap_l.push_back(left_chan);
      cap_r.push_back(right_chan);
      if (valid_d === 1'b1) wide++;
    end
    valid_d <= valid;
  end

  // Expected sample: MSB-aligned, truncated or zero padded.
  function automatic logic [DW-1:0] fit(input logic [31:0] w, input int wl);
    logic [63:0] t;
    t = {32'd0, w} & ((64'd1 << wl) - 64'd1);
    if (wl >= DW) t = t >> (wl - DW);
    else          t = t << (DW - wl);
    return t[DW-1:0];
  endfunction

  // One sclk period: data and word select change on the falling edge.
  task automatic send_slot(input logic lr, input int h);
    sclk  = 1'b0;
    lrclk = lr;
    sdata = pend;
    #(h * 10);
    sclk = 1'b1;
    #(h * 10);
  endtask

  // Bit in each slot is the previous slot's word bit (one-bit delay).
  task automatic send_half(input logic lr, input logic [31:0] w,
                           input int wl, input int h);
    for (int i = 0; i < wl; i++) begin
      send_slot(lr, h);
      pend = w[wl-1-i];
    end
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r,
                           input int wl, input int h);
    send_half(1'b0, l, wl, h);
    send_half(1'b1, r, wl, h);
    exp_l.push_back(fit(l, wl));
    exp_r.push_back(fit(r, wl));
  endtask

  // Trailing boundary so the last right word is finalised.
  task automatic flush(input int h);
    send_half(1'b0, 32'd0, 2, h);
    sclk = 1'b0;
    #400;
  endtask

  task automatic begin_run();
    reset_n = 1'b0;
    sclk    = 1'b0;
    lrclk   = 1'b1;
    sdata   = 1'b0;
    pend    = 1'b0;
    repeat (3) @(posedge clk);
    exp_l.delete(); exp_r.delete();
    cap_l.delete(); cap_r.delete();
    wide = 0;
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    begin_run();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (left_chan !== '0) begin
      tests_failed++;
      $display("FAIL reset_left got %h exp 0", left_chan);
    end
    tests_run++;
    if (right_chan !== '0) begin
      tests_failed++;
      $display("FAIL reset_right got %h exp 0", right_chan);
    end
    tests_run++;
    if ({valid, locked} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_flags got %b exp 00", {valid, locked});
    end
    #20 reset_n = 1'b1;
  endtask

  task automatic test_loopback();
    begin_run();
    for (int i = 0; i < 4; i++) send_pair(32'hA55A, 32'h1234, 16, 4);
    flush(4);
    tests_run++;
    if (cap_l.size() != 4) begin
      tests_failed++;
      $display("FAIL loop_count got %0d exp 4", cap_l.size());
    end
    for (int i = 0; i < cap_l.size() && i < 4; i++) begin
      tests_run++;
      if (cap_l[i] !== 16'hA55A || cap_r[i] !== 16'h1234) begin
        tests_failed++;
        $display("FAIL loop_pair%0d got %h/%h exp a55a/1234",
                 i, cap_l[i], cap_r[i]);
      end
    end
    tests_run++;
    if (locked !== 1'b1 || wide != 0) begin
      tests_failed++;
      $display("FAIL loop_lock got locked=%b wide=%0d exp 1/0", locked, wide);
    end
  endtask

  task automatic test_startup();
    begin_run();
    reset_n = 1'b0;
    send_half(1'b1, 32'h5A5A, 6, 4);
    reset_n = 1'b1;
    send_half(1'b1, 32'h00FF, 10, 4);
    tests_run++;
    if (cap_l.size() != 0 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_partial got n=%0d locked=%b exp 0/0",
               cap_l.size(), locked);
    end
    send_pair(32'h0001, 32'h8000, 16, 4);
    send_pair(32'h7FFF, 32'hFFFF, 16, 4);
    flush(4);
    tests_run++;
    if (cap_l.size() != exp_l.size()) begin
      tests_failed++;
      $display("FAIL start_count got %0d exp %0d", cap_l.size(), exp_l.size());
    end
    for (int i = 0; i < cap_l.size() && i < exp_l.size(); i++) begin
      tests_run++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        tests_failed++;
        $display("FAIL start_pair%0d got %h/%h exp %h/%h",
                 i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_word_len();
    begin_run();
    send_pair(32'hABCDEF, 32'h123456, 24, 3);
    send_pair(32'hC3, 32'h3C, 8, 3);
    flush(3);
    tests_run++;
    if (cap_l.size() != 2) begin
      tests_failed++;
      $display("FAIL wlen_count got %0d exp 2", cap_l.size());
    end
    for (int i = 0; i < cap_l.size() && i < 2; i++) begin
      tests_run++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        tests_failed++;
        $display("FAIL wlen_pair%0d got %h/%h exp %h/%h",
                 i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    begin_run();
    send_pair(32'h1111, 32'h2222, 16, 4);
    send_half(1'b0, 32'h3333, 8, 4);
    tests_run++;
    if (cap_l.size() != 1 || left_chan !== 16'h1111) begin
      tests_failed++;
      $display("FAIL rmid_pre got n=%0d left=%h exp 1/1111",
               cap_l.size(), left_chan);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (left_chan !== '0 || right_chan !== '0 || valid !== 1'b0 ||
        locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_async got %h/%h v=%b l=%b exp zeros",
               left_chan, right_chan, valid, locked);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_l.delete(); exp_r.delete();
    cap_l.delete(); cap_r.delete();
    send_half(1'b1, 32'h3FF, 10, 4);
    send_half(1'b0, 32'hBEEF, 16, 4);
    tests_run++;
    if (cap_l.size() != 0 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_early got n=%0d locked=%b exp 0/0",
               cap_l.size(), locked);
    end
    pend = 1'b0;
    begin_run();
    send_half(1'b1, 32'h3FF, 10, 4);
    send_pair(32'hCAFE, 32'hF00D, 16, 4);
    send_pair(32'h0F0F, 32'hF0F0, 16, 4);
    flush(4);
    tests_run++;
    if (cap_l.size() != 2) begin
      tests_failed++;
      $display("FAIL rmid_count got %0d exp 2", cap_l.size());
    end
    for (int i = 0; i < cap_l.size() && i < 2; i++) begin
      tests_run++;
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
        tests_failed++;
        $display("FAIL rmid_pair%0d got %h/%h exp %h/%h",
                 i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_slow_ratio();
    int bad;
    begin_run();
    for (int i = 0; i < 100; i++) begin
      send_pair(32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)),
                16, 2);
    end
    flush(2);
    tests_run++;
    if (cap_l.size() != 100) begin
      tests_failed++;
      $display("FAIL slow_count got %0d exp 100", cap_l.size());
    end
    bad = 0;
    for (int i = 0; i < cap_l.size() && i < exp_l.size(); i++) begin
      if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL slow_pairs got %0d bad exp 0", bad);
    end
    tests_run++;
    if (wide != 0) begin
      tests_failed++;
      $display("FAIL slow_width got %0d wide pulses exp 0", wide);
    end
  endtask

  task automatic test_jitter();
    logic [31:0] pl[3];
    logic [31:0] pr[3];
    real off;
    for (int k = 0; k < 3; k++) begin
      pl[k] = 32'($urandom_range(0, 65535));
      pr[k] = 32'($urandom_range(0, 65535));
    end
    for (int j = 0; j < 4; j++) begin
      begin_run();
      off = real'($urandom_range(0, 90)) / 10.0;
      #(off);
      for (int k = 0; k < 3; k++) send_pair(pl[k], pr[k], 16, 2 + (j % 2));
      flush(3);
      tests_run++;
      if (cap_l.size() != 3) begin
        tests_failed++;
        $display("FAIL jit%0d_count got %0d exp 3", j, cap_l.size());
      end
      for (int i = 0; i < cap_l.size() && i < 3; i++) begin
        tests_run++;
        if (cap_l[i] !== exp_l[i] || cap_r[i] !== exp_r[i]) begin
          tests_failed++;
          $display("FAIL jit%0d_pair%0d got %h/%h exp %h/%h",
                   j, i, cap_l[i], cap_r[i], exp_l[i], exp_r[i]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sclk    = 1'b0;
    lrclk   = 1'b1;
    sdata   = 1'b0;
    test_reset();
    test_loopback();
    test_startup();
    test_word_len();
    test_reset_mid();
    test_slow_ratio();
    test_jitter();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
